// File: rtl/alarm_disp_pkg.sv
// rtl/alarm_disp_pkg.sv - shared display constants and helpers for the alarm clock display path
package alarm_disp_pkg;

  localparam int DIGITS_DEFAULT   = 4;
  localparam int SCAN_DIV_DEFAULT = 50000;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/digit_scan_ring_if.sv
// rtl/digit_scan_ring_if.sv - digit registers in, scanned select/code out
interface digit_scan_ring_if
  import alarm_disp_pkg::*;
#(
  parameter int NUM_DIGITS = DIGITS_DEFAULT,
  parameter int DATA_W     = 4
);

  localparam int IDX_W = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);

  logic                         enable;
  logic [NUM_DIGITS*DATA_W-1:0] digits_in;
  logic [NUM_DIGITS-1:0]        blank_mask;
  logic [NUM_DIGITS-1:0]        selector;
  logic [IDX_W-1:0]             digit_idx;
  logic [DATA_W-1:0]            digit_data;
  logic                         frame_tick;

  modport master (
    output enable, digits_in, blank_mask,
    input  selector, digit_idx, digit_data, frame_tick
  );

  modport slave (
    input  enable, digits_in, blank_mask,
    output selector, digit_idx, digit_data, frame_tick
  );

endinterface

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - divides enabled clk cycles into digit slots
module scan_prescaler
  import alarm_disp_pkg::*;
#(
  parameter int DIV = SCAN_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  // tick is combinational so the index advances on the same edge the count wraps
  assign tick = enable && (count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/digit_scan_ring.sv
// rtl/digit_scan_ring.sv - one-hot digit scan with per-digit blanking and frame pulse
module digit_scan_ring
  import alarm_disp_pkg::*;
#(
  parameter int NUM_DIGITS = DIGITS_DEFAULT,
  parameter int DIV        = SCAN_DIV_DEFAULT,
  parameter int DATA_W     = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               reset,
  digit_scan_ring_if.slave   bus
);

  localparam int IDX_W = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE =
    (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                  slot_end;
  logic [IDX_W-1:0]      index;
  logic                  wrap_q;
  logic [NUM_DIGITS-1:0] sel_next;
  logic [DATA_W-1:0]     data_next;
  logic                  blank_cur;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.enable),
    .tick   (slot_end)
  );

  always_comb begin
    sel_next  = SEL_IDLE;
    data_next = '0;
    blank_cur = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index == IDX_W'(i)) begin
        data_next   = bus.digits_in[i*DATA_W +: DATA_W];
        blank_cur   = bus.blank_mask[i];
        sel_next[i] = (ACTIVE_LOW == 0);
      end
    end
    if (blank_cur) sel_next = SEL_IDLE;
  end

  // frame_tick is delayed one extra stage so it lines up with the first digit-0 output cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      index          <= '0;
      wrap_q         <= 1'b0;
      bus.selector   <= SEL_IDLE;
      bus.digit_idx  <= '0;
      bus.digit_data <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      if (slot_end) index <= (index == LAST_IDX) ? '0 : index + 1'b1;
      wrap_q         <= slot_end && (index == LAST_IDX);
      bus.frame_tick <= wrap_q;
      bus.selector   <= sel_next;
      bus.digit_idx  <= index;
      bus.digit_data <= data_next;
    end
  end

endmodule

// File: tb/tb_digit_scan_ring.sv
// tb/tb_digit_scan_ring.sv - scoreboard bench for digit_scan_ring (4-digit DIV=4 and 3-digit DIV=1)
module tb_digit_scan_ring;
  import alarm_disp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   n_chk  = 0;
  int   n_fail = 0;

  digit_scan_ring_if #(.NUM_DIGITS(4), .DATA_W(4)) bus_a ();
  digit_scan_ring_if #(.NUM_DIGITS(3), .DATA_W(4)) bus_b ();

  digit_scan_ring #(.NUM_DIGITS(4), .DIV(4), .DATA_W(4), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a.slave));
  digit_scan_ring #(.NUM_DIGITS(3), .DIV(1), .DATA_W(4), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b.slave));

  // expected {sel[3:0], idx[1:0], data[3:0], frame_tick}
  logic [10:0] q[$];
  int m_cnt, m_idx;
  bit m_wrap;

  task automatic model_push(input bit rst, input bit en, input logic [15:0] din,
                            input logic [3:0] mask, input int n, input int div, input bit al);
    logic [3:0] full, idle, oh, sel;
    logic [1:0] idx;
    logic [3:0] data;
    logic       ft;
    bit         slot;
    full = 4'((1 << n) - 1);
    idle = al ? full : 4'b0000;
    if (rst) begin
      sel = idle; idx = 2'd0; data = 4'd0; ft = 1'b0;
      m_cnt = 0; m_idx = 0; m_wrap = 0;
    end else begin
      oh   = 4'(1 << m_idx);
      if (al) oh = ~oh & full;
      sel  = mask[m_idx] ? idle : oh;
      idx  = 2'(m_idx);
      data = din[m_idx*4 +: 4];
      ft   = m_wrap;
      slot = en && (m_cnt == div - 1);
      m_wrap = slot && (m_idx == n - 1);
      if (slot) begin
        m_cnt = 0;
        m_idx = (m_idx == n - 1) ? 0 : m_idx + 1;
      end else if (en) begin
        m_cnt++;
      end
    end
    q.push_back({sel, idx, data, ft});
  endtask

  task automatic step_a();
    model_push(rst_a, bus_a.enable, bus_a.digits_in, bus_a.blank_mask, 4, 4, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic step_b();
    model_push(rst_b, bus_b.enable, {4'h0, bus_b.digits_in}, {1'b0, bus_b.blank_mask}, 3, 1, 1'b0);
    @(posedge clk); #1;
  endtask

  function automatic logic [10:0] got_a();
    return {bus_a.selector, bus_a.digit_idx, bus_a.digit_data, bus_a.frame_tick};
  endfunction

  function automatic logic [10:0] got_b();
    return {1'b0, bus_b.selector, bus_b.digit_idx, bus_b.digit_data, bus_b.frame_tick};
  endfunction

  task automatic test_reset();
    logic [10:0] e;
    rst_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_a();
      e = q.pop_front();
      n_chk++;
      if (got_a() !== e) begin
        n_fail++; $display("FAIL reset_sb k=%0d got %h want %h", k, got_a(), e);
      end
      n_chk++;
      if ({bus_a.selector, bus_a.digit_idx, bus_a.digit_data, bus_a.frame_tick} !== {4'b1111, 2'd0, 4'd0, 1'b0}) begin
        n_fail++; $display("FAIL reset_idle k=%0d got %b/%0d/%0d/%b want 1111/0/0/0", k,
                           bus_a.selector, bus_a.digit_idx, bus_a.digit_data, bus_a.frame_tick);
      end
    end
  endtask

  task automatic test_scan_order();
    logic [10:0] e;
    logic [3:0]  one, want_sel;
    int d, pulses;
    bit want_ft;
    one = 4'b0001;
    pulses = 0;
    rst_a = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step_a();
      e = q.pop_front();
      n_chk++;
      if (got_a() !== e) begin
        n_fail++; $display("FAIL scan_sb k=%0d got %h want %h", k, got_a(), e);
      end
      d = ((k - 1) / 4) % 4;
      want_sel = ~(one << d);
      want_ft  = (k > 1) && ((k - 1) % 16 == 0);
      if (bus_a.frame_tick === 1'b1) pulses++;
      n_chk++;
      if (bus_a.selector !== want_sel || bus_a.digit_data !== 4'(d + 1) || bus_a.frame_tick !== want_ft) begin
        n_fail++; $display("FAIL scan_order k=%0d got %b/%0d/%b want %b/%0d/%b", k,
                           bus_a.selector, bus_a.digit_data, bus_a.frame_tick, want_sel, d + 1, want_ft);
      end
    end
    n_chk++;
    if (pulses !== 2) begin
      n_fail++; $display("FAIL frame_count got %0d want 2", pulses);
    end
  endtask

  task automatic test_enable_freeze();
    logic [10:0] e;
    rst_a = 1'b1; step_a(); void'(q.pop_front()); rst_a = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      bus_a.enable = !(k >= 11 && k <= 20);
      step_a();
      e = q.pop_front();
      n_chk++;
      if (got_a() !== e) begin
        n_fail++; $display("FAIL freeze_sb k=%0d got %h want %h", k, got_a(), e);
      end
      if (k >= 9 && k <= 22) begin
        n_chk++;
        if (bus_a.selector !== 4'b1011) begin
          n_fail++; $display("FAIL freeze_hold k=%0d got %b want 1011", k, bus_a.selector);
        end
      end
      if (k == 23) begin
        n_chk++;
        if (bus_a.selector !== 4'b0111 || bus_a.digit_idx !== 2'd3) begin
          n_fail++; $display("FAIL freeze_resume got %b/%0d want 0111/3", bus_a.selector, bus_a.digit_idx);
        end
      end
    end
    bus_a.enable = 1'b1;
  endtask

  task automatic test_blanking();
    logic [10:0] e;
    rst_a = 1'b1; step_a(); void'(q.pop_front()); rst_a = 1'b0;
    bus_a.blank_mask = 4'b0100;
    for (int k = 1; k <= 16; k++) begin
      if (k == 11) bus_a.blank_mask = 4'b0000;
      step_a();
      e = q.pop_front();
      n_chk++;
      if (got_a() !== e) begin
        n_fail++; $display("FAIL blank_sb k=%0d got %h want %h", k, got_a(), e);
      end
      if (k == 9 || k == 10) begin
        n_chk++;
        if (bus_a.selector !== 4'b1111 || bus_a.digit_data !== 4'd3) begin
          n_fail++; $display("FAIL blank_dark k=%0d got %b/%0d want 1111/3", k, bus_a.selector, bus_a.digit_data);
        end
      end
      if (k == 5 || k == 11 || k == 13) begin
        n_chk++;
        if (bus_a.selector !== ((k == 5) ? 4'b1101 : (k == 11) ? 4'b1011 : 4'b0111)) begin
          n_fail++; $display("FAIL blank_other k=%0d got %b", k, bus_a.selector);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] e;
    rst_a = 1'b1; step_a(); void'(q.pop_front()); rst_a = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step_a();
      e = q.pop_front();
      n_chk++;
      if (got_a() !== e) begin
        n_fail++; $display("FAIL midrst_sb k=%0d got %h want %h", k, got_a(), e);
      end
    end
    n_chk++;
    if (bus_a.digit_idx !== 2'd3) begin
      n_fail++; $display("FAIL midrst_pre got %0d want 3", bus_a.digit_idx);
    end
    rst_a = 1'b1; step_a(); e = q.pop_front(); rst_a = 1'b0;
    n_chk++;
    if (got_a() !== e || bus_a.selector !== 4'b1111 || bus_a.digit_idx !== 2'd0 || bus_a.digit_data !== 4'd0) begin
      n_fail++; $display("FAIL midrst_idle got %h want %h", got_a(), e);
    end
    for (int j = 1; j <= 8; j++) begin
      step_a();
      e = q.pop_front();
      n_chk++;
      if (got_a() !== e || bus_a.selector !== ((j <= 4) ? 4'b1110 : 4'b1101)) begin
        n_fail++; $display("FAIL midrst_restart j=%0d got %h want %h", j, got_a(), e);
      end
    end
  endtask

  task automatic test_non_pow2();
    logic [10:0] e;
    logic [2:0]  one;
    int i;
    one = 3'b001;
    rst_b = 1'b1; step_b(); e = q.pop_front(); rst_b = 1'b0;
    n_chk++;
    if (got_b() !== e) begin
      n_fail++; $display("FAIL np2_reset got %h want %h", got_b(), e);
    end
    for (int k = 1; k <= 12; k++) begin
      step_b();
      e = q.pop_front();
      i = (k - 1) % 3;
      n_chk++;
      if (got_b() !== e) begin
        n_fail++; $display("FAIL np2_sb k=%0d got %h want %h", k, got_b(), e);
      end
      n_chk++;
      if (bus_b.digit_idx !== 2'(i) || bus_b.selector !== (one << i) ||
          bus_b.frame_tick !== ((k > 1) && (i == 0))) begin
        n_fail++; $display("FAIL np2_seq k=%0d got %0d/%b/%b want %0d", k,
                           bus_b.digit_idx, bus_b.selector, bus_b.frame_tick, i);
      end
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.enable     = 1'b1;
    bus_a.digits_in  = 16'h4321;
    bus_a.blank_mask = 4'b0000;
    bus_b.enable     = 1'b1;
    bus_b.digits_in  = 12'h321;
    bus_b.blank_mask = 3'b000;
    test_reset();
    test_scan_order();
    test_enable_freeze();
    test_blanking();
    test_reset_mid();
    test_non_pow2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
